data_mem_responder: RTL and testbench

- Responder side of the MEM-stage load/store interface: a byte-addressable data memory that serves one request at a time over a valid/ready request and response handshake.
- Performs byte/halfword/word alignment checks, store lane merging and load sign/zero extension, all selected by the BHW code.
- Also provides a registered word-read debug port for the debug unit to dump memory.
- Sits between the pipeline MEM stage (initiator) and on-chip RAM.

---
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/data_mem_responder.sv | 139 +++++++++++++
 tb/tb_data_mem_responder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the MEM-stage initiator and the data memory responder.
// Signal names keep the responder-side direction prefixes so both ends trace to the same wires.
interface data_mem_responder_if #(
  parameter int unsigned NB_WIDTH = 32
);
  logic                i_req_valid;
  logic                o_req_ready;
  logic                i_req_we;
  logic [NB_WIDTH-1:0] i_req_addr;
  logic [NB_WIDTH-1:0] i_req_wdata;
  logic [2:0]          i_req_bhw;
  logic                o_rsp_valid;
  logic                i_rsp_ready;
  logic [NB_WIDTH-1:0] o_rsp_rdata;
  logic                o_rsp_err;

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_bhw, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_bhw, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressable data memory serving one load/store at a time (IDLE -> ACCESS -> RESP),
// with alignment/range checks, lane-merged stores, extended loads and a registered debug read.
module data_mem_responder #(
  parameter int unsigned NB_WIDTH = 32,
  parameter int unsigned NB_ADDR  = 9,
  parameter int unsigned NB_DATA  = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  data_mem_responder_if.slave bus,
  input  logic [NB_ADDR-1:0]  i_dbg_addr,
  output logic [NB_WIDTH-1:0] o_dbg_data
);
  localparam int unsigned NB_LANES = NB_WIDTH / NB_DATA;
  localparam int unsigned DEPTH    = 2 ** NB_ADDR;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic                we_q;
  logic [NB_WIDTH-1:0] addr_q, wdata_q, rdata_q, rdata_d, dbg_q, dbg_word, rd_word;
  logic [2:0]          bhw_q;
  logic                err_q;
  logic                req_ready, rsp_valid, accept, mem_we;
  logic [2:0]          nbytes;
  logic                sext, bhw_ok, misaligned, out_of_range, acc_err;
  logic [NB_ADDR-1:0]  base, dbg_base;
  logic                unused_dbg_lsbs;

  logic [NB_DATA-1:0]  mem [DEPTH];

  assign base            = addr_q[NB_ADDR-1:0];
  assign dbg_base        = {i_dbg_addr[NB_ADDR-1:2], 2'b00};
  assign unused_dbg_lsbs = ^i_dbg_addr[1:0];

  // Access decode from the latched request.
  always_comb begin
    nbytes = 3'd1;
    sext   = 1'b0;
    bhw_ok = 1'b1;
    case (bhw_q)
      3'b000:  sext = 1'b1;
      3'b001:  begin nbytes = 3'd2; sext = 1'b1; end
      3'b011:  nbytes = 3'd4;
      3'b100:  bhw_ok = !we_q;
      3'b101:  begin nbytes = 3'd2; bhw_ok = !we_q; end
      default: bhw_ok = 1'b0;
    endcase
    misaligned   = ((nbytes == 3'd2) && addr_q[0]) || ((nbytes == 3'd4) && (addr_q[1:0] != 2'b00));
    out_of_range = |addr_q[NB_WIDTH-1:NB_ADDR];
    acc_err      = !bhw_ok || misaligned || out_of_range;
  end

  always_comb begin
    rd_word  = '0;
    dbg_word = '0;
    for (int k = 0; k < NB_LANES; k++) begin
      rd_word[k*NB_DATA +: NB_DATA]  = mem[base + NB_ADDR'(k)];
      dbg_word[k*NB_DATA +: NB_DATA] = mem[dbg_base + NB_ADDR'(k)];
    end
  end

  always_comb begin
    rdata_d = '0;
    if (!acc_err && !we_q) begin
      case (nbytes)
        3'd1: rdata_d = {{(NB_WIDTH-NB_DATA){sext & rd_word[NB_DATA-1]}}, rd_word[NB_DATA-1:0]};
        3'd2: rdata_d = {{(NB_WIDTH-2*NB_DATA){sext & rd_word[2*NB_DATA-1]}},
                         rd_word[2*NB_DATA-1:0]};
        default: rdata_d = rd_word;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (bus.i_req_valid) begin
          accept  = 1'b1;
          state_d = StAccess;
        end
      end
      StAccess: state_d = StResp;
      StResp: begin
        rsp_valid = 1'b1;
        if (bus.i_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_we = (state_q == StAccess) && we_q && !acc_err;

  // Storage is never reset; an async reset drops state_q out of ACCESS so no partial commit.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int k = 0; k < NB_LANES; k++) begin
        if (3'(k) < nbytes) mem[base + NB_ADDR'(k)] <= wdata_q[k*NB_DATA +: NB_DATA];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bhw_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      dbg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.i_req_we;
        addr_q  <= bus.i_req_addr;
        wdata_q <= bus.i_req_wdata;
        bhw_q   <= bus.i_req_bhw;
      end
      if (state_q == StAccess) begin
        rdata_q <= rdata_d;
        err_q   <= acc_err;
      end
      dbg_q <= dbg_word;
    end
  end

  assign bus.o_req_ready = req_ready;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_rsp_err   = err_q;
  assign o_dbg_data      = dbg_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-array transaction model,
// with a per-cycle compare process and directed literal scenarios.
module tb_data_mem_responder;
  localparam int unsigned NB_WIDTH = 32;
  localparam int unsigned NB_ADDR  = 9;
  localparam int unsigned NB_DATA  = 8;
  localparam int unsigned DEPTH    = 512;

  logic                i_clk = 1'b0;
  logic                i_reset = 1'b1;
  logic [NB_ADDR-1:0]  i_dbg_addr = '0;
  logic [NB_WIDTH-1:0] o_dbg_data;

  data_mem_responder_if #(.NB_WIDTH(NB_WIDTH)) bus ();

  data_mem_responder #(
    .NB_WIDTH(NB_WIDTH),
    .NB_ADDR (NB_ADDR),
    .NB_DATA (NB_DATA)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .bus       (bus),
    .i_dbg_addr(i_dbg_addr),
    .o_dbg_data(o_dbg_data)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [7:0]  model_mem [DEPTH];
  int          phase = 0;        // 0 idle, 1 access, 2 response
  bit          chk_en = 1'b0;
  bit          dbg_en = 1'b0;
  logic [31:0] exp_rdata = '0;
  bit          exp_err = 1'b0;
  logic [31:0] exp_dbg;
  bit          pend = 1'b0;
  logic [31:0] pend_addr, pend_data;
  int          pend_nb;
  logic [8:0]  last_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [8:0] a);
    logic [8:0] b;
    b = {a[8:2], 2'b00};
    return {model_mem[b + 9'd3], model_mem[b + 9'd2], model_mem[b + 9'd1], model_mem[b]};
  endfunction

  task automatic model_eval(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] bhw, output logic [31:0] r, output bit e);
    int nb;
    bit sx, ok;
    logic [31:0] v;
    nb = 1; sx = 0; ok = 1;
    case (bhw)
      3'b000:  sx = 1;
      3'b001:  begin nb = 2; sx = 1; end
      3'b011:  nb = 4;
      3'b100:  ok = !we;
      3'b101:  begin nb = 2; ok = !we; end
      default: ok = 0;
    endcase
    e = !ok || (addr % nb != 0) || (addr >= DEPTH);
    r = '0;
    pend = 0;
    if (!e) begin
      if (we) begin
        pend = 1; pend_addr = addr; pend_data = wdata; pend_nb = nb;
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(model_mem[addr + i]) << (8 * i));
        if (sx && v[8 * nb - 1]) v = v - (32'd1 << (8 * nb));
        r = v;
      end
    end
  endtask

  task automatic drive_junk();
    bus.i_req_valid = 1'($urandom_range(0, 1));
    bus.i_req_we    = 1'($urandom_range(0, 1));
    bus.i_req_addr  = 32'($urandom_range(0, 511));
    bus.i_req_wdata = $urandom;
    bus.i_req_bhw   = 3'($urandom_range(0, 7));
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    pend = 0;
    phase = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    bus.i_req_valid = 1'b0;
  endtask

  // Called one step after a clock edge, with the model in the idle phase.
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] bhw, input int hold, input int abort,
                        input bit pin, input logic [31:0] lit_rdata, input bit lit_err);
    logic [31:0] r;
    bit e;
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = we;
    bus.i_req_addr  = addr;
    bus.i_req_wdata = wdata;
    bus.i_req_bhw   = bhw;
    bus.i_rsp_ready = 1'($urandom_range(0, 1));
    @(posedge i_clk);
    #1;
    model_eval(we, addr, wdata, bhw, r, e);
    if (pin) begin
      check("model_rdata", r, lit_rdata);
      check("model_err", 32'(e), 32'(lit_err));
    end
    exp_rdata = r;
    exp_err   = e;
    phase     = 1;
    last_addr = addr[8:0];
    drive_junk();
    if (abort == 1) begin
      do_reset();
      return;
    end
    @(posedge i_clk);
    #1;
    if (pend) for (int i = 0; i < pend_nb; i++) model_mem[pend_addr + i] = pend_data[8*i +: 8];
    pend = 0;
    phase = 2;
    drive_junk();
    bus.i_rsp_ready = (hold == 0);
    if (abort == 2) begin
      do_reset();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge i_clk);
      #1;
      drive_junk();
      bus.i_rsp_ready = (h == hold - 1);
    end
    @(posedge i_clk);
    #1;
    phase = 0;
    bus.i_req_valid = 1'b0;
  endtask

  // Debug word expected: memory contents as they stood just before each edge.
  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) exp_dbg <= '0;
    else          exp_dbg <= model_word(i_dbg_addr);
  end

  always @(posedge i_clk) begin
    #1;
    if ($urandom_range(0, 1) == 1) i_dbg_addr = last_addr;
    else                           i_dbg_addr = 9'($urandom);
  end

  // Single compare process, every falling edge.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      check("rst_req_ready", 32'(bus.o_req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
      check("rst_rsp_rdata", bus.o_rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(bus.o_rsp_err), 32'd0);
      check("rst_dbg_data", o_dbg_data, 32'd0);
    end else if (chk_en) begin
      check("req_ready", 32'(bus.o_req_ready), 32'(phase == 0));
      check("rsp_valid", 32'(bus.o_rsp_valid), 32'(phase == 2));
      if (phase == 2) begin
        check("rsp_rdata", bus.o_rsp_rdata, exp_rdata);
        check("rsp_err", 32'(bus.o_rsp_err), 32'(exp_err));
      end
      if (dbg_en) check("dbg_data", o_dbg_data, exp_dbg);
    end
  end

  initial begin
    bit          we;
    logic [31:0] addr;
    logic [2:0]  bhw;
    int          ab;
    bus.i_req_valid = 1'b0;
    bus.i_req_we    = 1'b0;
    bus.i_req_addr  = '0;
    bus.i_req_wdata = '0;
    bus.i_req_bhw   = '0;
    bus.i_rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    #2 i_reset = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    chk_en = 1'b1;

    for (int w = 0; w < DEPTH / 4; w++) do_txn(1, 32'(w * 4), $urandom, 3'b011, 0, 0, 0, 0, 0);
    dbg_en = 1'b1;

    // Loads of every width from one stored word
    do_txn(1, 32'h10, 32'hDEADBEEF, 3'b011, 0, 0, 1, 32'h0, 0);
    do_txn(0, 32'h10, 32'h0, 3'b000, 0, 0, 1, 32'hFFFFFFEF, 0);
    do_txn(0, 32'h13, 32'h0, 3'b100, 1, 0, 1, 32'h000000DE, 0);
    do_txn(0, 32'h12, 32'h0, 3'b001, 0, 0, 1, 32'hFFFFDEAD, 0);
    do_txn(0, 32'h12, 32'h0, 3'b101, 2, 0, 1, 32'h0000DEAD, 0);
    do_txn(0, 32'h10, 32'h0, 3'b011, 0, 0, 1, 32'hDEADBEEF, 0);
    // Lane merging
    do_txn(1, 32'h20, 32'h11223344, 3'b011, 0, 0, 1, 32'h0, 0);
    do_txn(1, 32'h21, 32'hFFFFFFAB, 3'b000, 0, 0, 1, 32'h0, 0);
    do_txn(1, 32'h22, 32'h9999CDEF, 3'b001, 0, 0, 1, 32'h0, 0);
    do_txn(0, 32'h20, 32'h0, 3'b011, 0, 0, 1, 32'hCDEFAB44, 0);
    // Error cases
    do_txn(1, 32'h04, 32'h0, 3'b011, 0, 0, 1, 32'h0, 0);
    do_txn(0, 32'h03, 32'h0, 3'b001, 0, 0, 1, 32'h0, 1);
    do_txn(1, 32'h06, 32'hFFFFFFFF, 3'b011, 0, 0, 1, 32'h0, 1);
    do_txn(0, 32'h200, 32'h0, 3'b011, 0, 0, 1, 32'h0, 1);
    do_txn(0, 32'h04, 32'h0, 3'b011, 0, 0, 1, 32'h0, 0);
    do_txn(0, 32'h04, 32'h0, 3'b010, 0, 0, 1, 32'h0, 1);
    do_txn(1, 32'h04, 32'hFFFFFFFF, 3'b100, 0, 0, 1, 32'h0, 1);
    do_txn(0, 32'h04, 32'h0, 3'b011, 0, 0, 1, 32'h0, 0);
    // Response held off for 5 cycles
    do_txn(0, 32'h10, 32'h0, 3'b011, 5, 0, 1, 32'hDEADBEEF, 0);
    // Reset mid-RESP, and reset during ACCESS of a store (no commit)
    do_txn(1, 32'h30, 32'h5A5AA5A5, 3'b011, 0, 0, 1, 32'h0, 0);
    do_txn(0, 32'h30, 32'h0, 3'b011, 3, 2, 1, 32'h5A5AA5A5, 0);
    do_txn(0, 32'h30, 32'h0, 3'b011, 0, 0, 1, 32'h5A5AA5A5, 0);
    do_txn(1, 32'h30, 32'h12345678, 3'b011, 0, 1, 1, 32'h0, 0);
    do_txn(0, 32'h30, 32'h0, 3'b011, 0, 0, 1, 32'h5A5AA5A5, 0);

    for (int t = 0; t < 400; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge i_clk);
        #1;
      end
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       addr = 32'h200 + 32'($urandom_range(0, 15));
        1:       addr = $urandom;
        default: addr = 32'($urandom_range(0, 511));
      endcase
      if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFFFFFC;
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 4))
          0: bhw = 3'b000;
          1: bhw = 3'b001;
          2: bhw = 3'b011;
          3: bhw = 3'b100;
          default: bhw = 3'b101;
        endcase
      end else begin
        bhw = 3'($urandom_range(0, 7));
      end
      ab = 0;
      if ($urandom_range(0, 49) == 0) ab = $urandom_range(1, 2);
      do_txn(we, addr, $urandom, bhw, $urandom_range(0, 3), ab, 0, 0, 0);
    end

    repeat (2) @(posedge i_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
